// File: rtl/div_pulse_check.sv
// div_pulse_check
//
// Receive-side checker for a divided-clock enable stream. Measures the spacing
// between single-cycle strobes, compares it with the expected divide ratio DIV,
// and reports the measured period, a lock indication and a saturating error count.
//
// Ports:
//   clk            single clock, all logic on its rising edge
//   rst            synchronous active-high reset
//   pi_strobe      divided enable pulse under check, sampled every cycle
//   pi_clr         synchronous clear of po_err_cnt (wins over a same-cycle error)
//   po_period      last measured strobe interval in cycles
//   po_period_vld  one-cycle pulse when po_period updates
//   po_lock        high while the strobe is verified at DIV spacing
//   po_err         one-cycle pulse per mismatch or timeout
//   po_err_cnt     saturating error count
//
// All outputs are registered; each reflects the strobe sampled at the previous edge.

module div_pulse_check #(
    parameter int unsigned DIV      = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_strobe,
    input  logic             pi_clr,
    output logic [CNT_W-1:0] po_period,
    output logic             po_period_vld,
    output logic             po_lock,
    output logic             po_err,
    output logic [ERR_W-1:0] po_err_cnt
);

    localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] DivVal     = CNT_W'(DIV);
    // Gap value at which 2*DIV cycles have elapsed since the last strobe.
    localparam logic [CNT_W-1:0] TimeoutGap = CNT_W'(2 * DIV - 1);
    localparam logic [GoodW-1:0] LockVal    = GoodW'(LOCK_CNT);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StLocked
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_vld_q, period_vld_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [CNT_W-1:0] interval;
    logic [GoodW-1:0] good_inc;
    logic             interval_ok;
    logic             timeout;

    always_comb begin
        interval    = gap_q + 1'b1;
        good_inc    = good_q + 1'b1;
        interval_ok = (interval == DivVal);
        timeout     = !pi_strobe && (gap_q == TimeoutGap);

        state_d      = state_q;
        good_d       = good_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        err_d        = 1'b0;
        // The gap counter free-runs; it is only interpreted in ARMED/LOCKED.
        gap_d        = pi_strobe ? '0 : gap_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                // First strobe only establishes a reference point.
                if (pi_strobe) begin
                    state_d = StArmed;
                    good_d  = '0;
                end
            end
            StArmed: begin
                if (pi_strobe) begin
                    period_d     = interval;
                    period_vld_d = 1'b1;
                    if (interval_ok) begin
                        good_d = good_inc;
                        if (good_inc == LockVal) begin
                            state_d = StLocked;
                        end
                    end else begin
                        good_d = '0;
                        err_d  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = StIdle;
                    good_d  = '0;
                    err_d   = 1'b1;
                end
            end
            StLocked: begin
                if (pi_strobe) begin
                    period_d     = interval;
                    period_vld_d = 1'b1;
                    if (!interval_ok) begin
                        state_d = StArmed;
                        good_d  = '0;
                        err_d   = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = StIdle;
                    good_d  = '0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                good_d  = '0;
            end
        endcase

        lock_d = (state_d == StLocked);

        // Clear wins over a same-cycle error; po_err still pulses in that case.
        if (pi_clr) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            gap_q        <= '0;
            good_q       <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            good_q       <= good_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            lock_q       <= lock_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign po_period     = period_q;
    assign po_period_vld = period_vld_q;
    assign po_lock       = lock_q;
    assign po_err        = err_q;
    assign po_err_cnt    = err_cnt_q;

endmodule
